cc_game_sequencer: RTL and testbench

CC_GAME_SEQUENCER -- requirements
Module: cc_game_sequencer

---
 rtl/cc_game_sequencer.sv | 166 ++++++++++++++++
 tb/tb_cc_game_sequencer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cc_game_sequencer.sv
// Game-flow sequencer: IDLE/PLAY/LEVELUP/CRASH/GAMEOVER/CHAMPION.
// Define CC_GAME_SEQUENCER_WIN_DEBOUNCE_EN to require WIN_HOLD-cycle wins.
module cc_game_sequencer #(
  parameter int NUMBER_LEVELS = 4,
  parameter int NUMBER_LIVES  = 3,
  parameter int WIN_HOLD      = 4
) (
  input  logic       CC_GAME_SEQUENCER_CLOCK_50,
  input  logic       CC_GAME_SEQUENCER_RESET_InHigh,
  input  logic       CC_GAME_SEQUENCER_start_InLow,
  input  logic       CC_GAME_SEQUENCER_win_InLow,
  input  logic       CC_GAME_SEQUENCER_crash_InLow,
  output logic       CC_GAME_SEQUENCER_clear_OutHigh,
  output logic       CC_GAME_SEQUENCER_frogreset_OutHigh,
  output logic [2:0] CC_GAME_SEQUENCER_level_OutBus,
  output logic [2:0] CC_GAME_SEQUENCER_lives_OutBus,
  output logic [2:0] CC_GAME_SEQUENCER_state_OutBus,
  output logic       CC_GAME_SEQUENCER_run_OutHigh
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PLAY     = 3'd1,
    S_LEVELUP  = 3'd2,
    S_CRASH    = 3'd3,
    S_GAMEOVER = 3'd4,
    S_CHAMPION = 3'd5
  } state_t;

  localparam logic [2:0] LAST_LEVEL = 3'(NUMBER_LEVELS - 1);
  localparam logic [2:0] FULL_LIVES = 3'(NUMBER_LIVES);

  logic clk;
  logic rst;
  logic start_n;
  logic win_n;
  logic crash_n;

  assign clk     = CC_GAME_SEQUENCER_CLOCK_50;
  assign rst     = CC_GAME_SEQUENCER_RESET_InHigh;
  assign start_n = CC_GAME_SEQUENCER_start_InLow;
  assign win_n   = CC_GAME_SEQUENCER_win_InLow;
  assign crash_n = CC_GAME_SEQUENCER_crash_InLow;

  state_t     state;
  state_t     state_nx;
  logic [2:0] level;
  logic [2:0] level_nx;
  logic [2:0] lives;
  logic [2:0] lives_nx;
  logic       clear;
  logic       clear_nx;
  logic       frog;
  logic       frog_nx;
  logic       run;
  logic       run_nx;
  logic       win_event;
  logic       in_play;

  assign in_play = (state == S_PLAY);

`ifdef CC_GAME_SEQUENCER_WIN_DEBOUNCE_EN
  localparam logic [7:0] HOLD_LAST = 8'(WIN_HOLD - 1);

  logic [7:0] win_cnt;
  logic [7:0] win_cnt_nx;

  // Count consecutive low PLAY cycles; the WIN_HOLD-th one is the event.
  always_comb begin
    win_event  = in_play && !win_n && (win_cnt == HOLD_LAST);
    win_cnt_nx = 8'd0;
    if (in_play && !win_n && !win_event) begin
      win_cnt_nx = win_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_cnt <= 8'd0;
    end else begin
      win_cnt <= win_cnt_nx;
    end
  end
`else
  assign win_event = in_play && !win_n;
`endif

  always_comb begin
    state_nx = state;
    level_nx = level;
    lives_nx = lives;
    clear_nx = 1'b0;
    frog_nx  = 1'b0;
    case (state)
      S_IDLE: begin
        if (!start_n) begin
          state_nx = S_PLAY;
          level_nx = 3'd0;
          lives_nx = FULL_LIVES;
          clear_nx = 1'b1;
        end
      end
      S_PLAY: begin
        if (win_event) begin
          state_nx = S_LEVELUP;
        end else if (!crash_n) begin
          state_nx = S_CRASH;
        end
      end
      S_LEVELUP: begin
        if (level >= LAST_LEVEL) begin
          state_nx = S_CHAMPION;
        end else begin
          state_nx = S_PLAY;
          level_nx = level + 3'd1;
          clear_nx = 1'b1;
        end
      end
      S_CRASH: begin
        if (lives <= 3'd1) begin
          state_nx = S_GAMEOVER;
          lives_nx = 3'd0;
        end else begin
          state_nx = S_PLAY;
          lives_nx = lives - 3'd1;
          frog_nx  = 1'b1;
        end
      end
      S_GAMEOVER, S_CHAMPION: begin
        if (!start_n) begin
          state_nx = S_IDLE;
        end
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
    run_nx = (state_nx == S_PLAY);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      level <= 3'd0;
      lives <= FULL_LIVES;
      clear <= 1'b0;
      frog  <= 1'b0;
      run   <= 1'b0;
    end else begin
      state <= state_nx;
      level <= level_nx;
      lives <= lives_nx;
      clear <= clear_nx;
      frog  <= frog_nx;
      run   <= run_nx;
    end
  end

  assign CC_GAME_SEQUENCER_clear_OutHigh     = clear;
  assign CC_GAME_SEQUENCER_frogreset_OutHigh = frog;
  assign CC_GAME_SEQUENCER_level_OutBus      = level;
  assign CC_GAME_SEQUENCER_lives_OutBus      = lives;
  assign CC_GAME_SEQUENCER_state_OutBus      = state;
  assign CC_GAME_SEQUENCER_run_OutHigh       = run;

endmodule

// File: tb/tb_cc_game_sequencer.sv
// Bench for cc_game_sequencer: directed game scenarios plus random play
// checked every cycle against a rule-level model of the game flow.
module tb_cc_game_sequencer;

  localparam int NLV = 4;
  localparam int NLF = 3;
  localparam int WH  = 4;
`ifdef CC_GAME_SEQUENCER_WIN_DEBOUNCE_EN
  localparam int HOLD = WH;
`else
  localparam int HOLD = 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start_n;
  logic       win_n;
  logic       crash_n;
  logic       clear;
  logic       frog;
  logic [2:0] level;
  logic [2:0] lives;
  logic [2:0] state;
  logic       run;

  int n_cmp = 0;
  int n_bad = 0;

  int m_state;
  int m_level;
  int m_lives;
  int m_wc;
  int m_clear;
  int m_frog;
  int m_run;

  cc_game_sequencer #(
    .NUMBER_LEVELS(NLV),
    .NUMBER_LIVES (NLF),
    .WIN_HOLD     (WH)
  ) dut (
    .CC_GAME_SEQUENCER_CLOCK_50         (clk),
    .CC_GAME_SEQUENCER_RESET_InHigh     (rst),
    .CC_GAME_SEQUENCER_start_InLow      (start_n),
    .CC_GAME_SEQUENCER_win_InLow        (win_n),
    .CC_GAME_SEQUENCER_crash_InLow      (crash_n),
    .CC_GAME_SEQUENCER_clear_OutHigh    (clear),
    .CC_GAME_SEQUENCER_frogreset_OutHigh(frog),
    .CC_GAME_SEQUENCER_level_OutBus     (level),
    .CC_GAME_SEQUENCER_lives_OutBus     (lives),
    .CC_GAME_SEQUENCER_state_OutBus     (state),
    .CC_GAME_SEQUENCER_run_OutHigh      (run)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act,
                     input int exp);
    n_cmp++;
    if (act !== 8'(exp)) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_level = 0;
    m_lives = NLF;
    m_wc    = 0;
    m_clear = 0;
    m_frog  = 0;
    m_run   = 0;
  endtask

  // Game rules, one clock at a time, in terms of codes and counts.
  task automatic model_step();
    bit win_ev;
    if (rst) return;
    m_clear = 0;
    m_frog  = 0;
    case (m_state)
      0: if (!start_n) begin
        m_state = 1;
        m_level = 0;
        m_lives = NLF;
        m_clear = 1;
      end
      1: begin
        m_wc   = win_n ? 0 : m_wc + 1;
        win_ev = (m_wc >= HOLD);
        if (win_ev) m_state = 2;
        else if (!crash_n) m_state = 3;
      end
      2: if (m_level == NLV - 1) begin
        m_state = 5;
      end else begin
        m_level = m_level + 1;
        m_clear = 1;
        m_state = 1;
      end
      3: if (m_lives == 1) begin
        m_lives = 0;
        m_state = 4;
      end else begin
        m_lives = m_lives - 1;
        m_frog  = 1;
        m_state = 1;
      end
      default: if (!start_n) m_state = 0;
    endcase
    if (m_state != 1) m_wc = 0;
    m_run = (m_state == 1) ? 1 : 0;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    chk("state", state, m_state);
    chk("level", level, m_level);
    chk("lives", lives, m_lives);
    chk("clear", clear, m_clear);
    chk("frogreset", frog, m_frog);
    chk("run", run, m_run);
  end

  task automatic tick(input logic s, input logic w, input logic c);
    start_n = s;
    win_n   = w;
    crash_n = c;
    @(negedge clk);
    #2;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, state, 0);
    chk({tag, "_level"}, level, 0);
    chk({tag, "_lives"}, lives, 3);
    chk({tag, "_clear"}, clear, 0);
    chk({tag, "_frog"}, frog, 0);
    chk({tag, "_run"}, run, 0);
  endtask

  int wrun;

  initial begin
    rst     = 1'b1;
    start_n = 1'b1;
    win_n   = 1'b1;
    crash_n = 1'b1;
    model_reset();
    #3;
    chk_reset_vals("por");
    @(negedge clk);
    #2;
    rst = 1'b0;

    tick(0, 1, 1);
    chk("go_state", state, 1);
    chk("go_lives", lives, 3);
    chk("go_level", level, 0);
    chk("go_clear", clear, 1);
    chk("go_run", run, 1);
    tick(1, 1, 1);
    chk("go_clear_end", clear, 0);

    for (int k = 0; k < 3; k++) begin
      tick(1, 1, 0);
      chk("crash_state", state, 3);
      tick(1, 1, 1);
      if (k < 2) begin
        chk("crash_back", state, 1);
        chk("crash_lives", lives, 2 - k);
        chk("crash_frog", frog, 1);
        tick(1, 1, 1);
        chk("crash_frog_end", frog, 0);
      end else begin
        chk("over_state", state, 4);
        chk("over_lives", lives, 0);
        chk("over_run", run, 0);
        chk("over_frog", frog, 0);
      end
    end

    tick(0, 1, 1);
    chk("over_start", state, 0);
    tick(0, 1, 1);
    chk("restart", state, 1);
    tick(0, 1, 1);
    chk("play_start_ign", state, 1);
    chk("play_no_clear", clear, 0);

    for (int k = 0; k < 4; k++) begin
      repeat (HOLD) tick(1, 0, 1);
      chk("win_levelup", state, 2);
      tick(1, 1, 1);
      if (k < 3) begin
        chk("win_state", state, 1);
        chk("win_level", level, k + 1);
        chk("win_clear", clear, 1);
      end else begin
        chk("champ_state", state, 5);
        chk("champ_level", level, 3);
        chk("champ_clear", clear, 0);
      end
    end

    tick(0, 1, 1);
    chk("champ_start", state, 0);
    tick(0, 1, 1);
    chk("replay", state, 1);

    repeat (HOLD - 1) tick(1, 0, 1);
    tick(1, 1, 1);
    chk("short_win_state", state, 1);
    chk("short_win_level", level, 0);

    repeat (HOLD - 1) tick(1, 0, 1);
    tick(1, 0, 0);
    chk("both_state", state, 2);
    chk("both_lives", lives, 3);
    tick(1, 1, 1);
    chk("both_level", level, 1);

    repeat (HOLD) tick(1, 0, 1);
    tick(1, 1, 1);
    chk("lvl2_level", level, 2);
    chk("lvl2_state", state, 1);

    rst = 1'b1;
    model_reset();
    #1;
    chk_reset_vals("midrst");
    #1;
    rst = 1'b0;
    tick(1, 1, 1);
    chk("idle_wait", state, 0);

    wrun = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b1;
        model_reset();
        #1;
        rst = 1'b0;
      end
      start_n = ($urandom_range(0, 3) != 0);
      crash_n = ($urandom_range(0, 9) != 0);
      if (wrun == 0 && $urandom_range(0, 5) == 0) begin
        wrun = $urandom_range(1, HOLD + 2);
      end
      win_n = (wrun == 0);
      if (wrun > 0) wrun--;
      @(negedge clk);
      #2;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
